// File: rtl/exu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exu_ctrl_pkg
//  Description : Shared definitions for the execute-stage controller.
//                This package holds the data widths, the bit positions of the
//                one-hot opinfo, ALU-op and branch-kind buses, the controller
//                state encoding, and the packed layout of one held
//                instruction entry.
//  Revision    : 1.0  initial release
// ============================================================================
package exu_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int PC_W     = 32;
    localparam int OPINFO_W = 8;
    localparam int ALU_W    = 10;
    localparam int BR_W     = 6;

    // Operation class. Exactly one of these bits is set for each instruction.
    localparam int OPI_REG    = 0;   // register-register ALU op
    localparam int OPI_IMM    = 1;   // register-immediate ALU op
    localparam int OPI_LUI    = 2;
    localparam int OPI_AUIPC  = 3;
    localparam int OPI_JAL    = 4;
    localparam int OPI_JALR   = 5;
    localparam int OPI_BRANCH = 6;
    localparam int OPI_LSU    = 7;   // load/store: address = src1 + imm

    // ALU operation. This bus is one-hot.
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLL  = 2;
    localparam int ALU_SLT  = 3;
    localparam int ALU_SLTU = 4;
    localparam int ALU_XOR  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_OR   = 8;
    localparam int ALU_AND  = 9;

    // Branch kind. This bus is one-hot.
    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_FULL2 = 2'd2
    } exu_state_e;

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [XLEN-1:0]     src1;
        logic [XLEN-1:0]     src2;
        logic [XLEN-1:0]     imm;
        logic [4:0]          rd;
        logic [OPINFO_W-1:0] opinfo;
        logic [ALU_W-1:0]    alu;
        logic [BR_W-1:0]     br;
    } exu_entry_t;

endpackage
`default_nettype wire

// File: rtl/exu_ctrl_alu.sv
`default_nettype none
// ============================================================================
//  Module      : exu_ctrl_alu
//  Description : Combinational ALU and branch comparator for the head entry.
//                Ports:
//                  opinfo_i / alu_i / branch_info_i : one-hot decode buses
//                  pc_i / src1_i / src2_i / imm_i   : operands
//                  res_o                            : ALU result (the link
//                                                     value pc+4 for jal/jalr)
//                  cnd_o                            : branch condition met
//  Revision    : 1.0  initial release
// ============================================================================
module exu_ctrl_alu
    import exu_ctrl_pkg::*;
(
    input  logic [OPINFO_W-1:0] opinfo_i,
    input  logic [ALU_W-1:0]    alu_i,
    input  logic [BR_W-1:0]     branch_info_i,
    input  logic [PC_W-1:0]     pc_i,
    input  logic [XLEN-1:0]     src1_i,
    input  logic [XLEN-1:0]     src2_i,
    input  logic [XLEN-1:0]     imm_i,
    output logic [XLEN-1:0]     res_o,
    output logic                cnd_o
);

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_sum;
    logic            w_force_add;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;

    always_comb begin
        // Operand A: pc for pc-relative ops, zero for lui, otherwise src1.
        w_a = src1_i;
        if (opinfo_i[OPI_AUIPC] | opinfo_i[OPI_JAL] | opinfo_i[OPI_JALR])
            w_a = pc_i;
        if (opinfo_i[OPI_LUI])
            w_a = '0;

        // Operand B: jumps add 4 to the pc, which produces the link value.
        w_b = '0;
        if (opinfo_i[OPI_REG] | opinfo_i[OPI_BRANCH])
            w_b = src2_i;
        if (opinfo_i[OPI_IMM] | opinfo_i[OPI_LSU] | opinfo_i[OPI_LUI] | opinfo_i[OPI_AUIPC])
            w_b = imm_i;
        if (opinfo_i[OPI_JAL] | opinfo_i[OPI_JALR])
            w_b = 32'd4;
    end

    assign w_sum       = w_a + w_b;
    assign w_force_add = opinfo_i[OPI_LUI] | opinfo_i[OPI_AUIPC] | opinfo_i[OPI_JAL]
                       | opinfo_i[OPI_JALR] | opinfo_i[OPI_LSU];

    always_comb begin
        res_o = '0;
        if (w_force_add)            res_o = w_sum;
        else if (alu_i[ALU_ADD])    res_o = w_sum;
        else if (alu_i[ALU_SUB])    res_o = w_a - w_b;
        else if (alu_i[ALU_SLL])    res_o = w_a << w_b[4:0];
        else if (alu_i[ALU_SLT])    res_o = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
        else if (alu_i[ALU_SLTU])   res_o = {{(XLEN-1){1'b0}}, w_a < w_b};
        else if (alu_i[ALU_XOR])    res_o = w_a ^ w_b;
        else if (alu_i[ALU_SRL])    res_o = w_a >> w_b[4:0];
        else if (alu_i[ALU_SRA])    res_o = $signed(w_a) >>> w_b[4:0];
        else if (alu_i[ALU_OR])     res_o = w_a | w_b;
        else if (alu_i[ALU_AND])    res_o = w_a & w_b;
    end

    assign w_eq  = (src1_i == src2_i);
    assign w_lt  = ($signed(src1_i) < $signed(src2_i));
    assign w_ltu = (src1_i < src2_i);

    assign cnd_o = (branch_info_i[BR_BEQ]  &  w_eq)
                 | (branch_info_i[BR_BNE]  & ~w_eq)
                 | (branch_info_i[BR_BLT]  &  w_lt)
                 | (branch_info_i[BR_BGE]  & ~w_lt)
                 | (branch_info_i[BR_BLTU] &  w_ltu)
                 | (branch_info_i[BR_BGEU] & ~w_ltu);

endmodule
`default_nettype wire

// File: rtl/exu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exu_ctrl
//  Description : Execute-stage controller. It holds decoded instructions in a
//                valid/ready pipeline slot, runs the head entry through the
//                ALU, and produces the result, the control-transfer redirect
//                and a count of executed results.
//                Ports:
//                  clk_i, rst_n_i (synchronous, active-low), flush_i
//                  in_valid_i / in_ready_o   : handshake from the IDU
//                  opinfo_i, alu_i, branch_info_i, pc_i, src1_i, src2_i,
//                  imm_i, rd_i               : decoded instruction
//                  out_valid_o / out_ready_i : handshake to the LSU/WBU
//                  res_o, rd_o, pc_o, opinfo_o, src2_o : head entry results
//                  redirect_o, redirect_pc_o : taken jump/branch and target
//                  exec_cnt_o                : results handed downstream
//                Build option:
//                  YSYX_23060251_EXU_SKID_EN -- adds a second (skid) entry
//                  and makes in_ready_o independent of out_ready_i.
//  Revision    : 1.0  initial release
// ============================================================================
module exu_ctrl
    import exu_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [OPINFO_W-1:0] opinfo_i,
    input  logic [ALU_W-1:0]    alu_i,
    input  logic [BR_W-1:0]     branch_info_i,
    input  logic [PC_W-1:0]     pc_i,
    input  logic [XLEN-1:0]     src1_i,
    input  logic [XLEN-1:0]     src2_i,
    input  logic [XLEN-1:0]     imm_i,
    input  logic [4:0]          rd_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     res_o,
    output logic [4:0]          rd_o,
    output logic [PC_W-1:0]     pc_o,
    output logic [OPINFO_W-1:0] opinfo_o,
    output logic [XLEN-1:0]     src2_o,
    output logic                redirect_o,
    output logic [PC_W-1:0]     redirect_pc_o,
    output logic [63:0]         exec_cnt_o
);

    exu_state_e      r_state;
    exu_state_e      w_state_n;
    exu_entry_t      r_head;
    exu_entry_t      w_head_n;
    exu_entry_t      w_in_entry;
`ifdef YSYX_23060251_EXU_SKID_EN
    exu_entry_t      r_skid;
    exu_entry_t      w_skid_n;
`endif
    logic [63:0]     r_exec_cnt;
    logic            w_in_hs;
    logic            w_out_hs;
    logic            w_out_fire;
    logic            w_cnd;
    logic [PC_W-1:0] w_jalr_sum;

    assign w_in_entry = '{pc: pc_i, src1: src1_i, src2: src2_i, imm: imm_i, rd: rd_i,
                          opinfo: opinfo_i, alu: alu_i, br: branch_info_i};

    assign out_valid_o = (r_state == ST_FULL) | (r_state == ST_FULL2);

`ifdef YSYX_23060251_EXU_SKID_EN
    assign in_ready_o = rst_n_i & ~flush_i & (r_state != ST_FULL2);
`else
    assign in_ready_o = rst_n_i & ~flush_i & ((r_state == ST_EMPTY) | out_ready_i);
`endif

    assign w_in_hs    = in_valid_i & in_ready_o;
    assign w_out_hs   = out_valid_o & out_ready_i;
    // A head that is flushed in the same cycle is discarded, so it is not counted.
    assign w_out_fire = w_out_hs & ~flush_i;

    always_comb begin
        w_state_n = r_state;
        w_head_n  = r_head;
`ifdef YSYX_23060251_EXU_SKID_EN
        w_skid_n  = r_skid;
`endif
        if (flush_i) begin
            w_state_n = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_hs) begin
                        w_state_n = ST_FULL;
                        w_head_n  = w_in_entry;
                    end
                end
                ST_FULL: begin
                    if (w_in_hs && w_out_hs) begin
                        w_head_n  = w_in_entry;
                    end else if (w_out_hs) begin
                        w_state_n = ST_EMPTY;
`ifdef YSYX_23060251_EXU_SKID_EN
                    end else if (w_in_hs) begin
                        w_state_n = ST_FULL2;
                        w_skid_n  = w_in_entry;
`endif
                    end
                end
`ifdef YSYX_23060251_EXU_SKID_EN
                ST_FULL2: begin
                    // The skid entry is younger, so it moves to the head.
                    if (w_out_hs) begin
                        w_state_n = ST_FULL;
                        w_head_n  = r_skid;
                    end
                end
`endif
                default: w_state_n = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_EMPTY;
            r_head     <= '0;
`ifdef YSYX_23060251_EXU_SKID_EN
            r_skid     <= '0;
`endif
            r_exec_cnt <= '0;
        end else begin
            r_state <= w_state_n;
            r_head  <= w_head_n;
`ifdef YSYX_23060251_EXU_SKID_EN
            r_skid  <= w_skid_n;
`endif
            if (w_out_fire)
                r_exec_cnt <= r_exec_cnt + 64'd1;
        end
    end

    exu_ctrl_alu u_alu (
        .opinfo_i      (r_head.opinfo),
        .alu_i         (r_head.alu),
        .branch_info_i (r_head.br),
        .pc_i          (r_head.pc),
        .src1_i        (r_head.src1),
        .src2_i        (r_head.src2),
        .imm_i         (r_head.imm),
        .res_o         (res_o),
        .cnd_o         (w_cnd)
    );

    assign rd_o       = r_head.rd;
    assign pc_o       = r_head.pc;
    assign opinfo_o   = r_head.opinfo;
    assign src2_o     = r_head.src2;
    assign exec_cnt_o = r_exec_cnt;

    assign w_jalr_sum    = r_head.src1 + r_head.imm;
    assign redirect_pc_o = r_head.opinfo[OPI_JALR]
                         ? (w_jalr_sum & ~{{(PC_W-1){1'b0}}, 1'b1})
                         : (r_head.pc + r_head.imm);

    // The redirect is only visible on an accepted, non-flushed output handshake.
    assign redirect_o = rst_n_i & w_out_fire
                      & (r_head.opinfo[OPI_JAL] | r_head.opinfo[OPI_JALR]
                         | (r_head.opinfo[OPI_BRANCH] & w_cnd));

endmodule
`default_nettype wire

// File: doc/exu_ctrl.md
EXU_CTRL -- requirements
Module: exu_ctrl

Interface
REQ-001 Port clk_i, input, 1, single rising-edge clock for all state.
REQ-002 Port rst_n_i, input, 1, reset; synchronous and active-low.
REQ-003 Port flush_i, input, 1, discard all held entries (mispredict/trap from later stage).
REQ-004 Port in_valid_i, input, 1, IDU presents a decoded instruction.
REQ-005 Port in_ready_o, output, 1, exu_ctrl can accept this cycle.
REQ-006 Ports opinfo_i / alu_i / branch_info_i, input, opinfo/alu/branch bus widths, decoded one-hot op class, ALU op and branch kind.
REQ-007 Ports pc_i / src1_i / src2_i / imm_i / rd_i, input, pc/reg/reg/imm/5 bits, instruction operands and destination.
REQ-008 Port out_valid_o, output, 1, executed result available to the LSU/WBU.
REQ-009 Port out_ready_i, input, 1, downstream accepts result.
REQ-010 Ports res_o / rd_o / pc_o / opinfo_o / src2_o, output, xlen/5/pc/opinfo/reg, result and pass-through fields of the head entry.
REQ-011 Ports redirect_o (1) / redirect_pc_o (pc width), output, taken control transfer and its target.
REQ-012 Port exec_cnt_o, output, 64, count of results handed downstream.

Function
REQ-013 Input handshake SHALL complete when in_valid_i & in_ready_o on a clock edge; the instruction fields SHALL be captured into an entry that cycle.
REQ-014 Output handshake SHALL complete when out_valid_o & out_ready_i; the head entry SHALL be released that edge.
REQ-015 The head entry SHALL drive an internal alu instance; res_o SHALL be valid in the same cycle out_valid_o rises (latency 1 cycle from input handshake to out_valid_o).
REQ-016 State machine SHALL have states EMPTY and FULL (plus FULL2 with skid, REQ-030): EMPTY->FULL on input handshake; FULL->EMPTY on output handshake without input handshake; FULL->FULL on simultaneous input and output handshakes (new entry replaces head).
REQ-017 out_valid_o SHALL be 1 exactly in FULL/FULL2.
REQ-018 Outputs SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-019 redirect_o SHALL pulse for exactly the cycle of the output handshake when the head is jal, jalr, or branch with ALU cnd_o=1; it SHALL be 0 otherwise.
REQ-020 redirect_pc_o SHALL be pc+imm for jal/branch and (src1+imm) with bit 0 cleared for jalr, computed at pc width with wrap-around.
REQ-021 For jal/jalr, res_o SHALL be pc+4 (link value) as produced by the ALU.
REQ-022 flush_i=1 SHALL force EMPTY next cycle, suppress redirect_o that cycle, and drop any same-cycle input handshake; in_ready_o SHALL be 0 while flush_i=1.
REQ-023 exec_cnt_o SHALL increment by 1 per output handshake, wrap from 2^64-1 to 0, and SHALL not increment on flushed entries.

Reset
REQ-024 With rst_n_i=0 at a clock edge: state EMPTY, out_valid_o=0, redirect_o=0, exec_cnt_o=0, all entry payload registers 0.
REQ-025 Reset mid-operation SHALL discard held entries without any output handshake or redirect.
REQ-026 in_ready_o SHALL be 0 during reset and 1 in the first cycle after reset release.

Configuration
REQ-027 Macro YSYX_23060251_EXU_SKID_EN SHALL select buffering depth.
REQ-028 Without it: in_ready_o = ~flush_i & (EMPTY | out_ready_i) (one entry, combinational ready path).
REQ-029 With it: in_ready_o = ~flush_i & ~FULL2, independent of out_ready_i (registered ready).
REQ-030 With it: FULL + input handshake without output handshake SHALL enter FULL2, placing the new instruction in a skid entry; FULL2 + output handshake SHALL move the skid entry to head and return to FULL; order SHALL be preserved.

Structure
REQ-031 State encoding and entry payload struct SHALL live in the shared package alongside the opinfo/alu/branch bit indices.
REQ-032 The existing alu module SHALL be instantiated as the sole sub-module; redirect target adders are local.

Verification
REQ-033 addi x1: src1=5, imm=7 presented, out_ready_i=1 -> out_valid_o next cycle, res_o=12, rd_o=1, exec_cnt_o=1 after handshake.
REQ-034 beq pc=0x80000000, src1=src2=3, imm=0x10 -> redirect_o=1 one cycle, redirect_pc_o=0x80000010; same with src2=4 -> redirect_o=0.
REQ-035 jalr pc=0x80000100, src1=0x80000203, imm=0 -> res_o=0x80000104, redirect_pc_o=0x80000202.
REQ-036 Hold out_ready_i=0 five cycles with a held entry -> outputs stable, single handshake when released; with skid, second instruction accepted then in_ready_o=0.
REQ-037 flush_i asserted while FULL (and FULL2) -> EMPTY next cycle, no redirect, exec_cnt_o unchanged.
REQ-038 rst_n_i=0 while FULL -> all REQ-024 values next cycle; back-to-back stream of 100 adds at out_ready_i=1 -> exec_cnt_o=100, one result per cycle.
